// File: rtl/csa_pkg.sv
// Shared types and default sizing for the CSA final carry-propagate adder pipeline.
package csa_pkg;

  localparam int unsigned CSA_WIDTH       = 48;
  localparam int unsigned CSA_CHUNK       = 12;
  localparam int unsigned CSA_NSTG        = CSA_WIDTH / CSA_CHUNK;
  localparam int unsigned CSA_STICKY_BITS = 22;

  // One pipeline stage's payload. Operand remainders are kept right-aligned so the
  // next chunk to add always sits at bit 0; resolved bits above the current chunk are zero.
  typedef struct packed {
    logic [CSA_WIDTH-1:0] resolved;
    logic                 carry;
    logic [CSA_WIDTH-1:0] sum_rem;
    logic [CSA_WIDTH-1:0] carry_rem;
    logic                 sticky;
  } csa_stage_t;

endpackage

// File: rtl/csa_chunk_add.sv
// Combinational W-bit adder with carry-in and carry-out; one instance per pipeline stage.
module csa_chunk_add
  import csa_pkg::*;
#(
  parameter int unsigned W = CSA_CHUNK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum_c,
  output logic         cout_c
);

  localparam int unsigned WE = W + 1;

  // Single chunk add; the extra bit captures the carry out.
  always_comb begin
    {cout_c, sum_c} = WE'(a) + WE'(b) + WE'(cin);
  end

endmodule

// File: rtl/csa_final_adder_pipe.sv
// Chunked, pipelined carry-propagate adder resolving a Wallace sum/carry pair into a
// binary product with valid/ready flow control. Optional sticky generation is enabled
// by defining CSA_FINAL_ADDER_STICKY_EN.
module csa_final_adder_pipe
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH       = CSA_WIDTH,
  parameter int unsigned CHUNK       = CSA_CHUNK,
  parameter int unsigned STICKY_BITS = CSA_STICKY_BITS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sum,
  input  logic [WIDTH-1:0] i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_product,
  output logic             o_cout,
  output logic             o_sticky
);

  localparam int unsigned NSTG = WIDTH / CHUNK;

  // Elaboration-time sanity checks on the configuration.
  if ((WIDTH % CHUNK) != 0) begin : g_chk_chunk
    $error("csa_final_adder_pipe: WIDTH must be a multiple of CHUNK");
  end
  if (WIDTH != CSA_WIDTH) begin : g_chk_width
    $error("csa_final_adder_pipe: WIDTH must match csa_pkg::CSA_WIDTH (payload struct size)");
  end
  if (STICKY_BITS > WIDTH) begin : g_chk_sticky
    $error("csa_final_adder_pipe: STICKY_BITS must not exceed WIDTH");
  end

  csa_stage_t       pipe_q  [NSTG];
  logic [NSTG-1:0]  v_q;
  logic [NSTG-1:0]  adv_c;
  logic [NSTG-1:0]  in_valid_c;
  csa_stage_t       prev_c  [NSTG];
  csa_stage_t       nxt_c   [NSTG];
  logic [CHUNK-1:0] add_a   [NSTG];
  logic [CHUNK-1:0] add_b   [NSTG];
  logic [CHUNK-1:0] add_s   [NSTG];
  logic [NSTG-1:0]  add_ci;
  logic [NSTG-1:0]  add_co;

  // Advance chain: a stage may load if it is empty or its successor is moving.
  always_comb begin
    adv_c         = '0;
    adv_c[NSTG-1] = ~v_q[NSTG-1] | i_ready;
    for (int k = int'(NSTG) - 2; k >= 0; k--) begin
      adv_c[k] = ~v_q[k] | adv_c[k+1];
    end
  end

  assign o_ready = adv_c[0];

  // Source of each stage: stage 0 sees the raw inputs, later stages see their predecessor.
  always_comb begin
    prev_c[0]     = '{resolved: '0, carry: 1'b0, sum_rem: i_sum, carry_rem: i_carry, sticky: 1'b0};
    in_valid_c    = '0;
    in_valid_c[0] = i_valid;
    for (int unsigned k = 1; k < NSTG; k++) begin
      prev_c[k]     = pipe_q[k-1];
      in_valid_c[k] = v_q[k-1];
    end
    for (int unsigned k = 0; k < NSTG; k++) begin
      add_a[k]  = prev_c[k].sum_rem[CHUNK-1:0];
      add_b[k]  = prev_c[k].carry_rem[CHUNK-1:0];
      add_ci[k] = prev_c[k].carry;
    end
  end

  // One chunk adder per stage keeps a single CHUNK-bit carry chain between registers.
  for (genvar g = 0; g < int'(NSTG); g++) begin : g_add
    csa_chunk_add #(
      .W (CHUNK)
    ) u_add (
      .a      (add_a[g]),
      .b      (add_b[g]),
      .cin    (add_ci[g]),
      .sum_c  (add_s[g]),
      .cout_c (add_co[g])
    );
  end

  // Next payload: merge the new chunk into the resolved bits and consume one chunk of operands.
  always_comb begin
    for (int unsigned k = 0; k < NSTG; k++) begin
      nxt_c[k]           = prev_c[k];
      nxt_c[k].resolved  = prev_c[k].resolved | (WIDTH'(add_s[k]) << (k * CHUNK));
      nxt_c[k].carry     = add_co[k];
      nxt_c[k].sum_rem   = prev_c[k].sum_rem >> CHUNK;
      nxt_c[k].carry_rem = prev_c[k].carry_rem >> CHUNK;
`ifdef CSA_FINAL_ADDER_STICKY_EN
      for (int unsigned j = 0; j < CHUNK; j++) begin
        if ((k * CHUNK + j) < STICKY_BITS) begin
          nxt_c[k].sticky = nxt_c[k].sticky | add_s[k][j];
        end
      end
`endif
    end
  end

  // Stage registers: load on advance, otherwise hold; reset drops everything in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q <= '0;
      for (int unsigned k = 0; k < NSTG; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NSTG; k++) begin
        if (adv_c[k]) begin
          v_q[k] <= in_valid_c[k];
          if (in_valid_c[k]) begin
            pipe_q[k] <= nxt_c[k];
          end
        end
      end
    end
  end

  assign o_valid   = v_q[NSTG-1];
  assign o_product = pipe_q[NSTG-1].resolved;
  assign o_cout    = pipe_q[NSTG-1].carry;

`ifdef CSA_FINAL_ADDER_STICKY_EN
  assign o_sticky = pipe_q[NSTG-1].sticky;

  // Operand remainders are fully consumed by the last stage.
  logic unused_tail;
  assign unused_tail = ^{pipe_q[NSTG-1].sum_rem, pipe_q[NSTG-1].carry_rem};
`else
  assign o_sticky = 1'b0;

  // Operand remainders and the constant-zero sticky bit are dead at the last stage.
  logic unused_tail;
  assign unused_tail = ^{pipe_q[NSTG-1].sum_rem, pipe_q[NSTG-1].carry_rem, pipe_q[NSTG-1].sticky};
`endif

endmodule

// File: doc/csa_final_adder_pipe.md
Name: csa_final_adder_pipe

Overview:
- Consumer end of the Wallace-tree multiplier path.
- Takes the redundant sum/carry vector pair from the final 3:2 merge and resolves it to one binary product.
- Uses a chunked, pipelined carry-propagate adder with valid/ready flow control and full backpressure.
- Sits between the Wallace merge and the FPU_MUL normaliser/rounder.

Parameters:
- WIDTH, 48: width of the operand vectors and the product.
- CHUNK, 12: bits resolved per pipeline stage. WIDTH must be a multiple of CHUNK; a compile-time check enforces this.
- STICKY_BITS, 22: number of low product bits ORed into the sticky flag (optional feature only).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input vector pair valid.
- o_ready  output  1  block can accept an input this cycle.
- i_sum  input  WIDTH  redundant sum vector.
- i_carry  input  WIDTH  redundant carry vector, already left-shifted; bit 0 is added like any other bit.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_product  output  WIDTH  (i_sum + i_carry) mod 2^WIDTH.
- o_cout  output  1  carry out of bit WIDTH-1.
- o_sticky  output  1  OR of o_product[STICKY_BITS-1:0]; constant 0 when the feature is compiled out.

Behaviour:
- Pipeline depth is NSTG = WIDTH/CHUNK stages (4 by default).
- Stage k register content:
  - valid bit;
  - resolved low bits [k*CHUNK+CHUNK-1:0];
  - chunk carry;
  - unresolved upper operand bits of i_sum and i_carry.
- Stage 0 captures the inputs and adds chunk 0 with carry-in 0.
- Stage k adds chunk k of the operands plus the carry from stage k-1.
- The final stage's carry is o_cout.
- Only one CHUNK-bit adder sits in any register-to-register path.
- Latency: an input accepted on cycle t gives o_valid=1 on cycle t+NSTG when i_ready has been held at 1.
- Throughput is one result per cycle.
- Advance rule:
  - adv[NSTG-1] = ~v[NSTG-1] | i_ready;
  - adv[k] = ~v[k] | adv[k+1];
  - o_ready = adv[0].
- A stage loads from its predecessor only when adv[k]=1. Otherwise it holds all its contents.
- Input handshake: a transfer happens when i_valid & o_ready. Inputs are not sampled otherwise.
- Output handshake: o_product, o_cout and o_sticky stay stable while o_valid=1 and i_ready=0.
- Bubbles collapse: an empty stage accepts data even when the output is stalled.
- Simultaneous input accept and output pop in the same cycle with a full pipeline is legal. No bubble is inserted.
- Reset: all valid bits go to 0 asynchronously. Therefore o_valid=0 and o_ready=1 after reset.
- Reset values: o_product=0, o_cout=0, o_sticky=0.
- Data registers are also cleared on reset.
- Reset mid-operation discards all in-flight results. No partial output is produced.
- No state machine beyond the per-stage valid bits.
- There are no combinational paths from i_* data to o_* data.
- o_ready depends combinationally on i_ready.

Optional Feature:
- Macro: CSA_FINAL_ADDER_STICKY_EN.
- When defined:
  - a running OR of the product bits below STICKY_BITS is accumulated as chunks resolve and is carried stage to stage;
  - o_sticky is registered with the result and aligned to o_valid.
- When undefined:
  - o_sticky is tied to 0 and no sticky logic is instantiated.
- Port list and latency are identical in both builds.

Decomposition:
- Shared package csa_pkg holds:
  - the default WIDTH and CHUNK localparams;
  - NSTG as WIDTH/CHUNK;
  - a packed struct type for one stage's payload (resolved bits, carry, remaining operand bits, sticky).
- Sub-module csa_chunk_add: a combinational CHUNK-bit adder with carry-in and carry-out. It is instantiated once per stage.

Test Plan:
- Ripple across all chunks: i_sum=48'hFFFF_FFFF_FFFF, i_carry=48'h1 -> o_product=0, o_cout=1, with o_valid asserted exactly 4 cycles after accept.
- Back-to-back stream with i_ready=1: 64 random pairs on consecutive cycles -> 64 consecutive results matching the reference sum in order, and o_ready stays 1 throughout.
- Backpressure: fill the pipeline, then hold i_ready=0 for 10 cycles.
  - o_ready falls once 4 entries are held.
  - The first result stays stable for all 10 cycles.
  - After release, all results arrive in order with no loss or duplication.
- Bubble collapse: send 1 item, hold i_ready=0, then send 3 more -> all accepted (o_ready=1) until the 4 stages are full.
- Reset mid-flight: assert i_rst_n=0 with 3 items in flight -> o_valid=0 immediately, and no stale result appears after release.
- Sticky (macro defined): i_sum=48'h0000_0000_0001, i_carry=0 -> o_sticky=1. With i_sum=48'h0000_0040_0000 and i_carry=0 (bit 22 set, at or above STICKY_BITS) -> o_sticky=0.
